// File: rtl/masked_remap_pkg.sv
// masked_remap_pkg: shared state encoding and index helpers
// for the masked table remap stage.
package masked_remap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int share_off(input int k, input int n);
        return k * n;
    endfunction

endpackage

// File: rtl/remap_chunk.sv
// remap_chunk: one share, one chunk of the XOR-index permute:
// bits[j] = tbl[(chunk*CHUNK_W + j) ^ mask].
module remap_chunk #(
    parameter int IDX_W   = 8,
    parameter int CHUNK_W = 64,
    parameter int CW      = 2,
    localparam int N      = 1 << IDX_W
) (
    input  logic [N-1:0]       tbl,
    input  logic [IDX_W-1:0]   mask,
    input  logic [CW-1:0]      chunk,
    output logic [CHUNK_W-1:0] bits
);

    always_comb begin
        bits = '0;
        for (int j = 0; j < CHUNK_W; j++) begin
            bits[j] = tbl[IDX_W'(32'(chunk) * CHUNK_W + j) ^ mask];
        end
    end

endmodule

// File: rtl/masked_table_remap.sv
// masked_table_remap: captures SHARES tables and writes S_k[i] = src_k[i ^ x]
// CHUNK_W bits per cycle. Define REFRESH_EN to XOR rnd into shares 0 and last.
module masked_table_remap
    import masked_remap_pkg::*;
#(
    parameter int SHARES  = 5,
    parameter int IDX_W   = 8,
    parameter int NMASK   = 4,
    parameter int CHUNK_W = 64,
    localparam int N      = 1 << IDX_W,
    localparam int SW     = (NMASK > 1) ? clog2(NMASK) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SW-1:0]         sel,
    input  logic [NMASK*IDX_W-1:0] x_flat,
    input  logic [SHARES*N-1:0]   srca_flat,
    input  logic [SHARES*N-1:0]   srcb_flat,
    input  logic [N-1:0]          rnd,
    output logic [SHARES*N-1:0]   s_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CHUNKS = N / CHUNK_W;
    localparam int CW     = (CHUNKS > 1) ? clog2(CHUNKS) : 1;

    state_t              st, st_n;
    logic [CW-1:0]       cnt;
    logic [SHARES*N-1:0] src_q, s_q;
    logic [IDX_W-1:0]    x_q;
    logic                err_q;
    logic                sel_bad, accept, bad;
    logic [CHUNK_W-1:0]  wr [SHARES];

    assign sel_bad = ({1'b0, sel} >= (SW+1)'(NMASK));
    assign accept  = start && (st == IDLE) && !sel_bad;
    assign bad     = start && (st == IDLE) && sel_bad;

`ifdef REFRESH_EN
    logic [CHUNK_W-1:0] rnd_c;
    assign rnd_c = rnd[32'(cnt) * CHUNK_W +: CHUNK_W];
`else
    logic unused_rnd;
    assign unused_rnd = ^rnd;
`endif

    for (genvar k = 0; k < SHARES; k++) begin : g_sh
        logic [CHUNK_W-1:0] perm;
        remap_chunk #(
            .IDX_W  (IDX_W),
            .CHUNK_W(CHUNK_W),
            .CW     (CW)
        ) u_rc (
            .tbl  (src_q[share_off(k, N) +: N]),
            .mask (x_q),
            .chunk(cnt),
            .bits (perm)
        );
`ifdef REFRESH_EN
        // Same mask on both outer shares keeps the share XOR intact.
        if (k == 0 || k == SHARES - 1) begin : g_ref
            assign wr[k] = perm ^ rnd_c;
        end else begin : g_pass
            assign wr[k] = perm;
        end
`else
        assign wr[k] = perm;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE:    if (accept) st_n = RUN;
            RUN:     if (cnt == CW'(CHUNKS - 1)) st_n = FIN;
            FIN:     st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            src_q <= '0;
            x_q   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bad;
            if (accept) begin
                src_q <= (sel == '0) ? srca_flat : srcb_flat;
                x_q   <= x_flat[32'(sel) * IDX_W +: IDX_W];
                cnt   <= '0;
            end
            if (st == RUN) begin
                for (int k = 0; k < SHARES; k++) begin
                    s_q[share_off(k, N) + 32'(cnt) * CHUNK_W +: CHUNK_W] <= wr[k];
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign s_flat = s_q;
    assign busy   = (st == RUN);
    assign done   = (st == FIN);
    assign err    = err_q;

endmodule

// File: tb/tb_masked_table_remap.sv
// Self-checking bench for masked_table_remap: default DUT plus a
// NMASK=5, single-chunk DUT for error and CHUNKS=1 cases.
module tb_masked_table_remap;

    localparam int SH = 5;
    localparam int N  = 256;
`ifdef REFRESH_EN
    localparam bit REF = 1'b1;
`else
    localparam bit REF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, start2;
    logic [1:0] sel;
    logic [2:0] sel2;
    logic [31:0] x_flat;
    logic [39:0] x_flat2;
    logic [SH*N-1:0] srca, srcb, s1, s2;
    logic [N-1:0] rnd;
    logic busy1, done1, err1, busy2, done2, err2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    masked_table_remap #(
        .SHARES(5), .IDX_W(8), .NMASK(4), .CHUNK_W(64)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .x_flat(x_flat), .srca_flat(srca), .srcb_flat(srcb),
        .rnd(rnd), .s_flat(s1), .busy(busy1), .done(done1),
        .err(err1)
    );

    masked_table_remap #(
        .SHARES(5), .IDX_W(8), .NMASK(5), .CHUNK_W(256)
    ) u2 (
        .clk(clk), .rst(rst), .start(start2), .sel(sel2),
        .x_flat(x_flat2), .srca_flat(srca), .srcb_flat(srcb),
        .rnd(rnd), .s_flat(s2), .busy(busy2), .done(done2),
        .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic chk_tbl(input string nm, input logic [N-1:0] a,
                           input logic [N-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [N-1:0] rt();
        logic [N-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SH*N-1:0] rall();
        logic [SH*N-1:0] r;
        for (int k = 0; k < SH; k++) r[k*N +: N] = rt();
        return r;
    endfunction

    function automatic logic [SH*N-1:0] pattern();
        logic [SH*N-1:0] r;
        for (int k = 0; k < SH; k++)
            for (int i = 0; i < N; i++)
                r[k*N + i] = 1'(((i * (k + 3)) >> 2) & 1);
        return r;
    endfunction

    // Reference: table read at the XOR-ed index.
    function automatic logic [N-1:0] remap(input logic [N-1:0] t,
                                           input logic [7:0] m);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = t[i ^ int'(m)];
        return r;
    endfunction

    task automatic run_op(input int d, input int s, input logic [7:0] m,
                          input logic [SH*N-1:0] a, input logic [SH*N-1:0] b,
                          input int exp_lat, input bit noise,
                          output logic [SH*N-1:0] exp);
        logic [SH*N-1:0] src;
        logic [N-1:0] reff, xo, xs, pl;
        int cw, lat, bcnt, ecnt;
        bit seen;
        cw = d ? 256 : 64;
        srca = a;
        srcb = b;
        src = (s == 0) ? a : b;
        if (d == 0) begin
            x_flat = $urandom;
            x_flat[s*8 +: 8] = m;
            sel = 2'(s);
            start = 1'b1;
        end else begin
            x_flat2 = {$urandom, 8'($urandom)};
            x_flat2[s*8 +: 8] = m;
            sel2 = 3'(s);
            start2 = 1'b1;
        end
        tick();
        start = 1'b0;
        start2 = 1'b0;
        reff = '0;
        lat = 0;
        bcnt = 0;
        ecnt = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            if ((d ? done2 : done1) === 1'b1) begin
                lat = cyc;
                seen = 1'b1;
            end else if ((d ? busy2 : busy1) === 1'b1) begin
                bcnt++;
            end
            if ((d ? err2 : err1) !== 1'b0) ecnt++;
            rnd = rt();
            for (int i = 0; i < N; i++)
                if (i / cw == cyc - 1) reff[i] = rnd[i];
            srca = rall();
            srcb = rall();
            x_flat = $urandom;
            x_flat2 = {$urandom, 8'($urandom)};
            if (noise && d == 0) begin
                start = 1'b1;
                sel = 2'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_cycles", 64'(bcnt), 64'(exp_lat - 1));
        chk("err_quiet", 64'(ecnt), 64'd0);
        chk("done_pulse", 64'(d ? done2 : done1), 64'd0);
        chk("idle_after", 64'(d ? busy2 : busy1), 64'd0);
        xo = '0;
        xs = '0;
        for (int k = 0; k < SH; k++) begin
            pl = remap(src[k*N +: N], m);
            if (REF && (k == 0 || k == SH - 1)) pl = pl ^ reff;
            exp[k*N +: N] = pl;
            chk_tbl($sformatf("share%0d", k),
                    d ? s2[k*N +: N] : s1[k*N +: N], pl);
            xo = xo ^ (d ? s2[k*N +: N] : s1[k*N +: N]);
            xs = xs ^ src[k*N +: N];
        end
        chk_tbl("share_xor", xo, remap(xs, m));
    endtask

    typedef struct {
        int d;
        int s;
        logic [7:0] m;
        bit pat;
        bit noise;
        int lat;
    } vec_t;

    vec_t tv [7];
    logic [SH*N-1:0] e1, e2, pa;
    int dcnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, 0, 8'h00, 1'b1, 1'b0, 5};
        tv[1] = '{0, 2, 8'hA5, 1'b0, 1'b0, 5};
        tv[2] = '{0, 1, 8'hFF, 1'b0, 1'b1, 5};
        tv[3] = '{0, 3, 8'h3C, 1'b0, 1'b1, 5};
        tv[4] = '{1, 0, 8'h00, 1'b0, 1'b0, 2};
        tv[5] = '{1, 4, 8'h81, 1'b0, 1'b0, 2};
        tv[6] = '{1, 2, 8'h7E, 1'b0, 1'b0, 2};

        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        sel = '0;
        sel2 = '0;
        x_flat = '0;
        x_flat2 = '0;
        srca = '0;
        srcb = '0;
        rnd = '0;
        repeat (3) tick();
        chk("rst_s1", 64'(|s1), 64'd0);
        chk("rst_s2", 64'(|s2), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        rst = 1'b0;
        tick();

        pa = pattern();
        for (int v = 0; v < 7; v++) begin
            if (tv[v].d == 0)
                run_op(0, tv[v].s, tv[v].m, tv[v].pat ? pa : rall(),
                       rall(), tv[v].lat, tv[v].noise, e1);
            else
                run_op(1, tv[v].s, tv[v].m, rall(), rall(),
                       tv[v].lat, tv[v].noise, e2);
            if (v == 0 && !REF) chk_tbl("identity0", s1[0 +: N], pa[0 +: N]);
        end

        for (int t = 0; t < 2; t++) begin
            sel2 = (t == 0) ? 3'd7 : 3'd5;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            chk("err_pulse", 64'(err2), 64'd1);
            chk("err_busy", 64'(busy2), 64'd0);
            tick();
            chk("err_clear", 64'(err2), 64'd0);
            chk("err_busy2", 64'(busy2), 64'd0);
            for (int k = 0; k < SH; k++)
                chk_tbl("err_keep", s2[k*N +: N], e2[k*N +: N]);
        end

        srca = rall();
        srcb = rall();
        x_flat = $urandom;
        sel = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_s", 64'(|s1), 64'd0);
        chk("mid_rst_busy", 64'(busy1), 64'd0);
        chk("mid_rst_done", 64'(done1), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done1 !== 1'b0 || busy1 !== 1'b0) dcnt++;
            tick();
        end
        chk("mid_rst_quiet", 64'(dcnt), 64'd0);
        run_op(0, 1, 8'h5A, rall(), rall(), 5, 1'b0, e1);
        run_op(0, 2, 8'h01, rall(), rall(), 5, 1'b1, e1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
